// File: rtl/mem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
//==============================================================================
// Module      : mem_arbiter
// Description : Two-port round-robin arbiter in front of a single fixed-latency
//               memory. The IDLE state picks a winner and latches its request.
//               ACCESS holds the memory strobes for MEM_LAT cycles. DONE pulses
//               ack to the winner for one cycle.
// Ports       : clk, rst_b      - clock, asynchronous active-low reset
//               req, we         - per-port request level / write select
//               addr, wdata     - per-port address / write data, {port1, port0}
//               ack             - per-port one-cycle completion pulse
//               rdata           - data of the most recent completed read
//               grant, busy     - owner of the transaction in flight / activity
//               mem_read/write  - memory strobes
//               mem_addr/wdata  - memory address / write data
//               mem_rdata       - memory read data, valid on last strobe cycle
// Revision    : 1.0 - initial release
//==============================================================================
module mem_arbiter #(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int MEM_LAT = 2
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic [1:0]      req,
    input  logic [1:0]      we,
    input  logic [2*AW-1:0] addr,
    input  logic [2*DW-1:0] wdata,
    output logic [1:0]      ack,
    output logic [DW-1:0]   rdata,
    output logic [1:0]      grant,
    output logic            busy,
    output logic            mem_read,
    output logic            mem_write,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;
    logic       last_grant;   // index of the port served most recently
    logic       lat_we;
    logic       win;          // index of the port that wins in this IDLE cycle

    // On a tie, the port that was not served last wins. A lone requester
    // always wins, because req[1] is its index.
    always_comb begin
        win = 1'b0;
        if (req == 2'b11) begin
            win = ~last_grant;
        end else begin
            win = req[1];
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|req) state_nxt = ACCESS;
            ACCESS:  if (cnt == 4'd1) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt        <= 4'd0;
            last_grant <= 1'b1;
            grant      <= 2'b00;
            lat_we     <= 1'b0;
            rdata      <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        grant     <= win ? 2'b10 : 2'b01;
                        lat_we    <= we[win];
                        mem_addr  <= win ? addr[2*AW-1:AW]  : addr[AW-1:0];
                        mem_wdata <= win ? wdata[2*DW-1:DW] : wdata[DW-1:0];
                        cnt       <= LAT_LOAD;
                    end
                end
                ACCESS: begin
                    cnt <= cnt - 4'd1;
                    // Memory data is only guaranteed on the last strobe cycle.
                    if (cnt == 4'd1 && !lat_we) begin
                        rdata <= mem_rdata;
                    end
                end
                DONE: begin
                    grant      <= 2'b00;
                    last_grant <= grant[1];
                end
                default: begin
                    grant <= 2'b00;
                end
            endcase
        end
    end

    // These outputs come straight from the state so that they drop as soon
    // as reset is asserted, even in the middle of an access.
    assign busy      = (state != IDLE);
    assign mem_read  = (state == ACCESS) && !lat_we;
    assign mem_write = (state == ACCESS) &&  lat_we;
    assign ack       = (state == DONE) ? grant : 2'b00;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
//==============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter (MEM_LAT=2 plus a
//               MEM_LAT=1 instance), directed scenarios and random traffic
//               against a transaction-level reference model.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_mem_arbiter;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst_b;
    logic [1:0]  req, we;
    logic [31:0] addr, wdata;
    logic [1:0]  ack, grant;
    logic [15:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic        busy, mem_read, mem_write;

    logic [1:0]  req_l1, we_l1, ack_l1, grant_l1;
    logic [31:0] addr_l1, wdata_l1;
    logic [15:0] rdata_l1, mem_addr_l1, mem_wdata_l1, mem_rdata_l1;
    logic        busy_l1, mem_read_l1, mem_write_l1;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    int          m_last;
    logic [15:0] m_rdata, m_maddr, m_mwdata;

    logic [3:0]  strb_cnt;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(16), .DW(16), .MEM_LAT(LAT)) dut (
        .clk(clk), .rst_b(rst_b), .req(req), .we(we), .addr(addr),
        .wdata(wdata), .ack(ack), .rdata(rdata), .grant(grant), .busy(busy),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_arbiter #(.AW(16), .DW(16), .MEM_LAT(1)) dut_l1 (
        .clk(clk), .rst_b(rst_b), .req(req_l1), .we(we_l1), .addr(addr_l1),
        .wdata(wdata_l1), .ack(ack_l1), .rdata(rdata_l1), .grant(grant_l1),
        .busy(busy_l1), .mem_read(mem_read_l1), .mem_write(mem_write_l1),
        .mem_addr(mem_addr_l1), .mem_wdata(mem_wdata_l1),
        .mem_rdata(mem_rdata_l1)
    );

    function automatic logic [15:0] memf(input logic [15:0] a);
        if (a == 16'h0010) return 16'hBEEF;
        return {a[7:0], a[15:8]} ^ 16'h5A5A;
    endfunction

    // Memory model: data is valid only on the last strobe cycle of a read.
    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) strb_cnt <= 4'd0;
        else        strb_cnt <= (mem_read || mem_write) ? strb_cnt + 4'd1 : 4'd0;
    end
    assign mem_rdata    = (mem_read && strb_cnt == 4'(LAT - 1)) ? memf(mem_addr) : 16'hDEAD;
    assign mem_rdata_l1 = mem_read_l1 ? memf(mem_addr_l1) : 16'hDEAD;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_last   = 1;
        m_rdata  = 16'h0000;
        m_maddr  = 16'h0000;
        m_mwdata = 16'h0000;
    endtask

    // Called during an IDLE cycle with a request presented. Runs the whole
    // transaction and returns during the DONE cycle.
    task automatic serve(input bit chg, input logic [15:0] newaddr);
        int          w;
        logic [1:0]  g;
        logic [15:0] a, d;
        logic        wr;
        if (req == 2'b11) w = 1 - m_last;
        else              w = req[1] ? 1 : 0;
        g  = (w == 1) ? 2'b10 : 2'b01;
        a  = addr[w*16 +: 16];
        d  = wdata[w*16 +: 16];
        wr = we[w];
        for (int i = 0; i < LAT; i++) begin
            step();
            chk("acc_grant", 32'(grant), 32'(g));
            chk("acc_busy", 32'(busy), 32'd1);
            chk("acc_ack", 32'(ack), 32'd0);
            chk("acc_mem_read", 32'(mem_read), 32'(!wr));
            chk("acc_mem_write", 32'(mem_write), 32'(wr));
            chk("acc_mem_addr", 32'(mem_addr), 32'(a));
            chk("acc_mem_wdata", 32'(mem_wdata), 32'(d));
            if (chg && i == 0) addr[w*16 +: 16] = newaddr;
        end
        step();
        chk("done_ack", 32'(ack), 32'(g));
        chk("done_grant", 32'(grant), 32'(g));
        chk("done_busy", 32'(busy), 32'd1);
        chk("done_strobes", 32'({mem_read, mem_write}), 32'd0);
        m_last = w;
        if (!wr) m_rdata = memf(a);
        m_maddr  = a;
        m_mwdata = d;
        chk("done_rdata", 32'(rdata), 32'(m_rdata));
    endtask

    // One cycle that must be IDLE.
    task automatic gap();
        step();
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_grant", 32'(grant), 32'd0);
        chk("idle_ack", 32'(ack), 32'd0);
        chk("idle_strobes", 32'({mem_read, mem_write}), 32'd0);
        chk("idle_mem_addr", 32'(mem_addr), 32'(m_maddr));
        chk("idle_mem_wdata", 32'(mem_wdata), 32'(m_mwdata));
        chk("idle_rdata", 32'(rdata), 32'(m_rdata));
    endtask

    initial begin
        rst_b = 1'b0;
        req = 2'b00; we = 2'b00; addr = 32'h0; wdata = 32'h0;
        req_l1 = 2'b00; we_l1 = 2'b00; addr_l1 = 32'h0; wdata_l1 = 32'h0;
        model_reset();
        repeat (2) step();

        // Reset state
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_strobes", 32'({mem_read, mem_write}), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_l1_rdata", 32'(rdata_l1), 32'd0);
        rst_b = 1'b1;

        // MEM_LAT=1: req visible from this IDLE cycle; ack on the 3rd cycle
        req_l1 = 2'b01; addr_l1 = 32'h0000_0033;
        step();
        chk("l1_access_read", 32'(mem_read_l1), 32'd1);
        chk("l1_access_ack", 32'(ack_l1), 32'd0);
        step();
        chk("l1_done_ack", 32'(ack_l1), 32'd1);
        chk("l1_rdata", 32'(rdata_l1), 32'(memf(16'h0033)));
        req_l1 = 2'b00;
        step();
        chk("l1_idle_ack", 32'(ack_l1), 32'd0);
        chk("l1_idle_busy", 32'(busy_l1), 32'd0);

        // Single read by port 0
        req = 2'b01; we = 2'b00; addr = 32'h0000_0010;
        serve(1'b0, 16'h0);
        chk("single_rdata", 32'(rdata), 32'h0000_BEEF);
        req = 2'b00;
        gap();

        // Tie right after reset: port 0 first, then port 1 write
        rst_b = 1'b0;
        step();
        rst_b = 1'b1;
        model_reset();
        req = 2'b11; we = 2'b10; addr = 32'h0200_0001; wdata = 32'h1234_0000;
        serve(1'b0, 16'h0);
        chk("tie_first_ack", 32'(ack), 32'd1);
        gap();
        serve(1'b0, 16'h0);
        chk("tie_write_keeps_rdata", 32'(rdata), 32'(memf(16'h0001)));
        gap();

        // Sustained contention: grants alternate 01,10,...
        for (int k = 0; k < 6; k++) begin
            serve(1'b0, 16'h0);
            chk("rr_alternate", 32'(grant), (k % 2 == 0) ? 32'd1 : 32'd2);
            gap();
        end
        req = 2'b00;
        gap();

        // Port 1 changes addr during ACCESS
        req = 2'b10; we = 2'b00; addr = 32'h0005_0000;
        serve(1'b1, 16'h0099);
        chk("chg_done_mem_addr", 32'(mem_addr), 32'h0000_0005);
        req = 2'b00;
        gap();

        // Reset in the 2nd ACCESS cycle
        req = 2'b01; we = 2'b00; addr = 32'h0000_0020;
        step();
        chk("rm_access1", 32'(mem_read), 32'd1);
        step();
        chk("rm_access2", 32'(mem_read), 32'd1);
        #2;
        rst_b = 1'b0;
        #1;
        chk("rm_busy", 32'(busy), 32'd0);
        chk("rm_grant", 32'(grant), 32'd0);
        chk("rm_strobes", 32'({mem_read, mem_write}), 32'd0);
        chk("rm_ack", 32'(ack), 32'd0);
        step();
        chk("rm_ack_hold", 32'(ack), 32'd0);
        chk("rm_rdata", 32'(rdata), 32'd0);
        rst_b = 1'b1;
        model_reset();
        serve(1'b0, 16'h0);
        req = 2'b00;
        gap();

        // Random traffic against the model
        for (int k = 0; k < 40; k++) begin
            req   = 2'($urandom_range(0, 3));
            we    = 2'($urandom);
            addr  = $urandom;
            wdata = $urandom;
            if (req != 2'b00) serve(1'b0, 16'h0);
            gap();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
